mem_port_arbiter: RTL

Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the five-stage pipeline.
- Serialises accesses, inserts a configurable multi-cycle memory latency, and returns read data with a one-cycle ack.
- Drives the per-stage stall requests that the pipeline ORs into its hold/bubble logic.
- Sits between the pipeline registers and the memory macro, replacing the separate instruction and data memories.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mem_port_arbiter_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DATA
  } gnt_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_counter.sv
// Loadable 3-bit down-counter that times the memory busy phase.
module mem_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] value,
  input  logic       dec,
  output logic       done
);

  logic [2:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign done = (count == 3'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage,
// serialising accesses and returning read data with a one-cycle ack.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int MAW     = 7,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           if_req,
  input  logic [31:0]    if_addr,
  input  logic           flush_if,
  output logic [DW-1:0]  if_rdata,
  output logic           if_ack,
  input  logic           dm_rd,
  input  logic           dm_wr,
  input  logic [31:0]    dm_addr,
  input  logic [DW-1:0]  dm_wdata,
  output logic [DW-1:0]  dm_rdata,
  output logic           dm_ack,
  output logic           mem_en,
  output logic           mem_we,
  output logic [MAW-1:0] mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           stall_if,
  output logic           stall_mem
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range 1..7");
  end

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  arb_state_t state;
  gnt_t       last_grant;
  logic       cancel;
  logic       fetch_elig;
  logic       data_elig;
  logic       grant_if;
  logic       grant_d;
  logic       cnt_done;

  // Byte-offset and out-of-window address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MAW+2], if_addr[1:0],
                              dm_addr[31:MAW+2], dm_addr[1:0]};

  // NOTE: give every always_comb output a default before any branch so no latch is inferred.
  always_comb begin
    fetch_elig = if_req & ~flush_if & ~if_ack;
    data_elig  = (dm_rd | dm_wr) & ~dm_ack;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    if (state == IDLE) begin
      grant_if = fetch_elig & (~data_elig | (last_grant == GNT_DATA));
      grant_d  = data_elig & ~grant_if;
    end
  end

  mem_lat_counter u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (grant_if | grant_d),
    .value (LAT_LOAD),
    .dec   (state != IDLE),
    .done  (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_DATA;
      cancel     <= 1'b0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= BUSY_I;
            last_grant <= GNT_IF;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr[MAW+1:2];
          end else if (grant_d) begin
            state      <= BUSY_D;
            last_grant <= GNT_DATA;
            mem_en     <= 1'b1;
            mem_we     <= dm_wr;
            mem_addr   <= dm_addr[MAW+1:2];
            mem_wdata  <= dm_wdata;
          end
        end
        BUSY_I: begin
          if (flush_if) cancel <= 1'b1;
          if (cnt_done) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            cancel <= 1'b0;
            // A flush in the final busy cycle still suppresses the ack.
            if (!(cancel || flush_if)) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        BUSY_D: begin
          if (cnt_done) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            dm_ack <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ack & ~flush_if;
  assign stall_mem = (dm_rd | dm_wr) & ~dm_ack;

`ifndef SYNTHESIS
  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(dm_rd && dm_wr));
`endif

endmodule
